// File: rtl/spartan_burst_framer_pkg.sv
// Shared types for the burst framer: FSM state encoding.
package spartan_burst_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_CLOSE = 2'd2
  } state_t;

endpackage

// File: rtl/spartan_burst_framer_idle_timer.sv
// Saturating idle counter; expire is high while the count sits at TIMEOUT-1.
module spartan_burst_framer_idle_timer #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic CLK,
  input  logic rst_in,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] MAX   = '1;

  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge CLK or posedge rst_in) begin
    if (rst_in) begin
      idle_cnt <= '0;
    end else if (clr) begin
      idle_cnt <= '0;
    end else if (en && (idle_cnt != MAX)) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  assign expire = (idle_cnt == LIMIT);

endmodule

// File: rtl/spartan_burst_framer.sv
// Frames a valid/ready stream into bursts of at most BURST_LEN beats; a one-beat
// hold register lets LAST be attached late on timeout or FLUSH.
module spartan_burst_framer
  import spartan_burst_framer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 64,
  parameter int TO_W       = 7
) (
  input  logic                  CLK,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  DIN_VAL,
  output logic                  DIN_RDY,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VAL,
  output logic                  DOUT_LAST,
  input  logic                  DOUT_RDY,
  input  logic                  FLUSH,
  output logic                  BUSY
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    hold_val;
  logic [CNT_W-1:0]        beat_cnt;

  logic out_free;
  logic accept;
  logic load_out;
  logic load_last;
  logic cnt_inc;
  logic cnt_clr;
  logic hold_load;
  logic hold_clr;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_expire;

  assign out_free = !DOUT_VAL || DOUT_RDY;
  assign accept   = DIN_VAL && DIN_RDY;
  assign BUSY     = hold_val || DOUT_VAL || (beat_cnt != '0);

  // FLUSH masks ready in HOLD so the held beat closes before anything new enters.
  always_comb begin
    DIN_RDY = 1'b0;
    case (state)
      ST_IDLE: DIN_RDY = !rst_in;
      ST_HOLD: DIN_RDY = !rst_in && out_free && !FLUSH;
      default: DIN_RDY = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    load_last  = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    hold_load  = 1'b0;
    hold_clr   = 1'b0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          hold_load  = 1'b1;
          tmr_clr    = 1'b1;
          state_next = (beat_cnt == CNT_LAST) ? ST_CLOSE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          load_out   = 1'b1;
          cnt_inc    = 1'b1;
          hold_load  = 1'b1;
          tmr_clr    = 1'b1;
          state_next = ((beat_cnt + CNT_W'(1)) == CNT_LAST) ? ST_CLOSE : ST_HOLD;
        end else begin
          tmr_en = 1'b1;
          if (FLUSH || tmr_expire) begin
            state_next = ST_CLOSE;
          end
        end
      end
      ST_CLOSE: begin
        if (out_free) begin
          load_out   = 1'b1;
          load_last  = 1'b1;
          cnt_clr    = 1'b1;
          hold_clr   = 1'b1;
          tmr_clr    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  spartan_burst_framer_idle_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_idle_timer (
    .CLK    (CLK),
    .rst_in (rst_in),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge CLK or posedge rst_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      hold_data <= '0;
      hold_val  <= 1'b0;
      beat_cnt  <= '0;
      DOUT      <= '0;
      DOUT_VAL  <= 1'b0;
      DOUT_LAST <= 1'b0;
    end else begin
      state <= state_next;

      if (hold_load) begin
        hold_data <= DIN;
        hold_val  <= 1'b1;
      end else if (hold_clr) begin
        hold_val <= 1'b0;
      end

      if (cnt_clr) begin
        beat_cnt <= '0;
      end else if (cnt_inc) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end

      // Output beat stays put until the sink takes it.
      if (load_out) begin
        DOUT      <= hold_data;
        DOUT_VAL  <= 1'b1;
        DOUT_LAST <= load_last;
      end else if (DOUT_RDY) begin
        DOUT_VAL  <= 1'b0;
        DOUT_LAST <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spartan_burst_framer.sv
// Directed and random checks of spartan_burst_framer with BURST_LEN=4, TIMEOUT=64.
module tb_spartan_burst_framer;

  localparam int DW = 32;
  localparam int BL = 4;
  localparam int CW = 3;
  localparam int TO = 64;
  localparam int TW = 7;

  logic          CLK = 1'b0;
  logic          rst_in = 1'b1;
  logic [DW-1:0] DIN = '0;
  logic          DIN_VAL = 1'b0;
  logic          DIN_RDY;
  logic [DW-1:0] DOUT;
  logic          DOUT_VAL;
  logic          DOUT_LAST;
  logic          DOUT_RDY = 1'b1;
  logic          FLUSH = 1'b0;
  logic          BUSY;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] in_data[$];
  int            in_cyc[$];
  logic [DW-1:0] out_data[$];
  logic          out_last[$];
  int            out_cyc[$];

  spartan_burst_framer #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .CNT_W      (CW),
    .TIMEOUT    (TO),
    .TO_W       (TW)
  ) dut (
    .CLK       (CLK),
    .rst_in    (rst_in),
    .DIN       (DIN),
    .DIN_VAL   (DIN_VAL),
    .DIN_RDY   (DIN_RDY),
    .DOUT      (DOUT),
    .DOUT_VAL  (DOUT_VAL),
    .DOUT_LAST (DOUT_LAST),
    .DOUT_RDY  (DOUT_RDY),
    .FLUSH     (FLUSH),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Transfers are decided at the next rising edge; record them mid-cycle.
  always @(negedge CLK) begin
    if (!rst_in) begin
      if (DIN_VAL && DIN_RDY) begin
        in_data.push_back(DIN);
        in_cyc.push_back(cyc);
      end
      if (DOUT_VAL && DOUT_RDY) begin
        out_data.push_back(DOUT);
        out_last.push_back(DOUT_LAST);
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    in_data.delete();
    in_cyc.delete();
    out_data.delete();
    out_last.delete();
    out_cyc.delete();
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    DIN     = d;
    DIN_VAL = 1'b1;
    @(negedge CLK);
    while (!DIN_RDY && n < 200) begin
      n++;
      @(negedge CLK);
    end
    if (!DIN_RDY) begin
      errors++;
      $display("FAIL push_timeout: DIN_RDY=%0b for data %h, required 1 within 200 cycles", DIN_RDY, d);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_out(input int n, input int bound);
    int k = 0;
    while (out_data.size() < n && k < bound) begin
      @(posedge CLK);
      #1;
      k++;
    end
    if (out_data.size() < n) begin
      errors++;
      $display("FAIL wait_out: got %0d output beats, required %0d", out_data.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (DOUT !== '0)      begin errors++; $display("FAIL rst_dout: got %h required 0", DOUT); end
    checks++; if (DOUT_VAL !== 1'b0) begin errors++; $display("FAIL rst_dout_val: got %b required 0", DOUT_VAL); end
    checks++; if (DOUT_LAST !== 1'b0) begin errors++; $display("FAIL rst_dout_last: got %b required 0", DOUT_LAST); end
    checks++; if (DIN_RDY !== 1'b0) begin errors++; $display("FAIL rst_din_rdy: got %b required 0", DIN_RDY); end
    checks++; if (BUSY !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b required 0", BUSY); end
    rst_in = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (DIN_RDY !== 1'b1) begin errors++; $display("FAIL post_rst_din_rdy: got %b required 1", DIN_RDY); end
    checks++; if (BUSY !== 1'b0)    begin errors++; $display("FAIL post_rst_busy: got %b required 0", BUSY); end
  endtask

  task automatic test_back_to_back();
    int gap;
    clear_logs();
    DOUT_RDY = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    DIN_VAL = 1'b0;
    wait_out(8, 100);
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (out_data.size() != 8) begin
      errors++; $display("FAIL b2b_count: got %0d beats required 8", out_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (out_data[i] !== DW'(i + 1)) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h required %h", i, out_data[i], i + 1);
        end
        checks++;
        if (out_last[i] !== ((i == 3) || (i == 7))) begin
          errors++; $display("FAIL b2b_last[%0d]: got %b required %b", i, out_last[i], (i == 3) || (i == 7));
        end
      end
      // Streaming output except a single bubble after the first LAST.
      for (int i = 1; i < 8; i++) begin
        gap = (i == 4) ? 2 : 1;
        checks++;
        if (out_cyc[i] - out_cyc[i-1] != gap) begin
          errors++; $display("FAIL b2b_gap[%0d]: got %0d cycles required %0d", i, out_cyc[i] - out_cyc[i-1], gap);
        end
      end
    end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b required 0", BUSY); end
  endtask

  task automatic test_timeout();
    clear_logs();
    push(32'hA);
    push(32'hB);
    push(32'hC);
    DIN_VAL = 1'b0;
    wait_out(3, 200);
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (out_data.size() != 3) begin
      errors++; $display("FAIL to_count: got %0d beats required 3", out_data.size());
    end else begin
      checks++; if (out_data[0] !== 32'hA || out_last[0] !== 1'b0) begin errors++; $display("FAIL to_beat0: got %h/%b required a/0", out_data[0], out_last[0]); end
      checks++; if (out_data[1] !== 32'hB || out_last[1] !== 1'b0) begin errors++; $display("FAIL to_beat1: got %h/%b required b/0", out_data[1], out_last[1]); end
      checks++; if (out_data[2] !== 32'hC || out_last[2] !== 1'b1) begin errors++; $display("FAIL to_beat2: got %h/%b required c/1", out_data[2], out_last[2]); end
      // Accept edge to output edge is TIMEOUT+1; recorded half a cycle either side adds one.
      checks++;
      if (out_cyc[2] - in_cyc[2] != TO + 2) begin
        errors++; $display("FAIL to_latency: got %0d cycles required %0d", out_cyc[2] - in_cyc[2], TO + 2);
      end
    end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL to_busy: got %b required 0", BUSY); end
  endtask

  task automatic test_flush();
    clear_logs();
    DOUT_RDY = 1'b1;
    push(32'h11);
    push(32'h22);
    DIN     = 32'h33;
    DIN_VAL = 1'b1;
    FLUSH   = 1'b1;
    @(negedge CLK);
    checks++; if (DIN_RDY !== 1'b0) begin errors++; $display("FAIL flush_rdy_mask: got %b required 0", DIN_RDY); end
    @(posedge CLK);
    #1;
    FLUSH = 1'b0;
    push(32'h33);
    DIN_VAL = 1'b0;
    wait_out(3, 200);
    checks++;
    if (out_data.size() != 3 || in_data.size() != 3) begin
      errors++; $display("FAIL flush_count: got %0d out %0d in required 3 3", out_data.size(), in_data.size());
    end else begin
      checks++; if (out_data[0] !== 32'h11 || out_last[0] !== 1'b0) begin errors++; $display("FAIL flush_beat0: got %h/%b required 11/0", out_data[0], out_last[0]); end
      checks++; if (out_data[1] !== 32'h22 || out_last[1] !== 1'b1) begin errors++; $display("FAIL flush_beat1: got %h/%b required 22/1", out_data[1], out_last[1]); end
      checks++; if (out_data[2] !== 32'h33 || out_last[2] !== 1'b1) begin errors++; $display("FAIL flush_beat2: got %h/%b required 33/1", out_data[2], out_last[2]); end
      checks++;
      if (out_cyc[1] - in_cyc[1] != 3) begin
        errors++; $display("FAIL flush_close_time: got %0d cycles required 3", out_cyc[1] - in_cyc[1]);
      end
      checks++;
      if (in_cyc[2] - in_cyc[1] != 3) begin
        errors++; $display("FAIL flush_stall_len: got %0d cycles required 3", in_cyc[2] - in_cyc[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] vals [20];
    for (int i = 0; i < 20; i++) vals[i] = $urandom;
    clear_logs();
    DOUT_RDY = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) push(vals[i]);
        DIN_VAL = 1'b0;
      end
      begin
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 10; k++) begin
          @(negedge CLK);
          checks++;
          if (DOUT_VAL !== 1'b1 || DOUT !== vals[0]) begin
            errors++; $display("FAIL bp_stable[%0d]: got %b/%h required 1/%h", k, DOUT_VAL, DOUT, vals[0]);
          end
          checks++;
          if (DIN_RDY !== 1'b0) begin
            errors++; $display("FAIL bp_din_rdy[%0d]: got %b required 0", k, DIN_RDY);
          end
        end
        checks++;
        if (in_data.size() != 2) begin
          errors++; $display("FAIL bp_accepts: got %0d required 2", in_data.size());
        end
        @(posedge CLK);
        #1;
        DOUT_RDY = 1'b1;
      end
    join
    wait_out(20, 300);
    checks++;
    if (out_data.size() != 20) begin
      errors++; $display("FAIL bp_count: got %0d beats required 20", out_data.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (out_data[i] !== vals[i] || out_last[i] !== ((i % BL) == BL - 1)) begin
          errors++; $display("FAIL bp_beat[%0d]: got %h/%b required %h/%b", i, out_data[i], out_last[i], vals[i], (i % BL) == BL - 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    DOUT_RDY = 1'b1;
    push(32'h1);
    push(32'h2);
    push(32'h3);
    DIN_VAL = 1'b0;
    @(posedge CLK);
    #2;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b required 1", BUSY); end
    rst_in = 1'b1;
    #1;
    checks++; if (DOUT !== '0)       begin errors++; $display("FAIL mid_rst_dout: got %h required 0", DOUT); end
    checks++; if (DOUT_VAL !== 1'b0) begin errors++; $display("FAIL mid_rst_val: got %b required 0", DOUT_VAL); end
    checks++; if (DOUT_LAST !== 1'b0) begin errors++; $display("FAIL mid_rst_last: got %b required 0", DOUT_LAST); end
    checks++; if (BUSY !== 1'b0)     begin errors++; $display("FAIL mid_rst_busy: got %b required 0", BUSY); end
    checks++; if (DIN_RDY !== 1'b0)  begin errors++; $display("FAIL mid_rst_rdy: got %b required 0", DIN_RDY); end
    @(posedge CLK);
    #1;
    rst_in = 1'b0;
    clear_logs();
    for (int i = 0; i < 4; i++) push(DW'(32'h41 + i));
    DIN_VAL = 1'b0;
    wait_out(4, 100);
    checks++;
    if (out_data.size() != 4) begin
      errors++; $display("FAIL mid_count: got %0d beats required 4", out_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_data[i] !== DW'(32'h41 + i) || out_last[i] !== (i == 3)) begin
          errors++; $display("FAIL mid_beat[%0d]: got %h/%b required %h/%b", i, out_data[i], out_last[i], 32'h41 + i, i == 3);
        end
      end
    end
  endtask

  task automatic test_random();
    int guard = 0;
    int len = 0;
    clear_logs();
    while (in_data.size() < 10000 && guard < 60000) begin
      DIN_VAL  = ($urandom_range(0, 3) != 0);
      DIN      = $urandom;
      DOUT_RDY = ($urandom_range(0, 3) != 0);
      FLUSH    = ($urandom_range(0, 15) == 0);
      @(posedge CLK);
      #1;
      guard++;
    end
    DIN_VAL  = 1'b0;
    FLUSH    = 1'b0;
    DOUT_RDY = 1'b1;
    checks++;
    if (in_data.size() != 10000) begin
      errors++; $display("FAIL rnd_accepts: got %0d required 10000", in_data.size());
    end
    wait_out(in_data.size(), 300);
    checks++;
    if (out_data.size() != in_data.size()) begin
      errors++; $display("FAIL rnd_count: got %0d beats required %0d", out_data.size(), in_data.size());
    end else begin
      for (int i = 0; i < out_data.size(); i++) begin
        checks++;
        if (out_data[i] !== in_data[i]) begin
          errors++; $display("FAIL rnd_order[%0d]: got %h required %h", i, out_data[i], in_data[i]);
        end
        len++;
        if (len > BL) begin
          errors++; $display("FAIL rnd_burst_len[%0d]: got %0d beats required <= %0d", i, len, BL);
        end
        if (out_last[i] === 1'b1) begin
          checks++;
          len = 0;
        end
      end
      checks++;
      if (out_last[out_last.size()-1] !== 1'b1) begin
        errors++; $display("FAIL rnd_final_last: got %b required 1", out_last[out_last.size()-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
